// File: rtl/dc_upsize.sv
// Narrow-to-wide stream packer: gathers RATIO beats of IN_W bits into one word
// with a lane mask, registered sof/eof and an abort path for a mid-word sof.
module dc_upsize #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_vld_i,
  output logic                  s_rdy_o,
  input  logic [IN_W-1:0]       s_data_i,
  input  logic                  s_sof_i,
  input  logic                  s_eof_i,
  output logic                  m_vld_o,
  input  logic                  m_rdy_i,
  output logic [IN_W*RATIO-1:0] m_data_o,
  output logic [RATIO-1:0]      m_be_o,
  output logic                  m_sof_o,
  output logic                  m_eof_o,
  output logic                  m_err_o,
  output logic [15:0]           abort_cnt_o
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int IW    = $clog2(RATIO);

  // Handshake: a beat moves when s_vld_i & s_rdy_o at a rising edge, a word
  // moves when m_vld_o & m_rdy_i; a valid side never withdraws an offer.
  logic [IN_W-1:0] acc [RATIO-1];
  logic [IW-1:0]   idx;
  logic            acc_sof;
  logic            rdy_q;

  logic             out_free;
  logic             sof_mid;
  logic             abort;
  logic             wr;
  logic             last;
  logic [OUT_W-1:0] word_data;
  logic [RATIO-1:0] word_be;

  assign out_free = !m_vld_o | m_rdy_i;
  assign sof_mid  = s_vld_i & s_sof_i & (idx != '0);
  assign abort    = sof_mid & out_free;
  assign s_rdy_o  = rdy_q & out_free & !sof_mid;
  assign wr       = s_vld_i & s_rdy_o;
  assign last     = (idx == IW'(RATIO - 1)) | s_eof_i;

  // Lane k in arrival order lands in physical lane P of the output word.
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    localparam int P = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
    logic            held;
    logic            take;
    logic [IN_W-1:0] lane_q;
    if (k < RATIO - 1) begin : g_acc
      assign held   = (idx > IW'(k));
      assign lane_q = acc[k];
    end else begin : g_top
      assign held   = 1'b0;
      assign lane_q = '0;
    end
    assign take                      = wr & (idx == IW'(k));
    assign word_be[P]                = held | take;
    assign word_data[P*IN_W +: IN_W] = take ? s_data_i : (held ? lane_q : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q       <= 1'b0;
      idx         <= '0;
      acc_sof     <= 1'b0;
      m_vld_o     <= 1'b0;
      m_data_o    <= '0;
      m_be_o      <= '0;
      m_sof_o     <= 1'b0;
      m_eof_o     <= 1'b0;
      m_err_o     <= 1'b0;
      abort_cnt_o <= '0;
      for (int k = 0; k < RATIO - 1; k++) acc[k] <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (m_vld_o & m_rdy_i) m_vld_o <= 1'b0;
      if ((wr & last) | abort) begin
        // A load in the same cycle as a read keeps the stage full.
        m_vld_o  <= 1'b1;
        m_data_o <= word_data;
        m_be_o   <= word_be;
        m_sof_o  <= acc_sof | (wr & (idx == '0) & s_sof_i);
        m_eof_o  <= abort | s_eof_i;
        m_err_o  <= abort;
        idx      <= '0;
        acc_sof  <= 1'b0;
        for (int k = 0; k < RATIO - 1; k++) acc[k] <= '0;
        if (abort && abort_cnt_o != 16'hFFFF) abort_cnt_o <= abort_cnt_o + 16'd1;
      end else if (wr) begin
        for (int k = 0; k < RATIO - 1; k++)
          if (idx == IW'(k)) acc[k] <= s_data_i;
        idx <= idx + IW'(1);
        if ((idx == '0) & s_sof_i) acc_sof <= 1'b1;
      end
    end
  end

endmodule
